clk_period_meter: RTL and testbench

Measures the period and high time, in `clk` cycles, of a slow square wave on `sig_in`. Typical sources are the divided clocks (/2, /4, /8) produced elsewhere in the design, so this block is the consumer/checker end of that divider. The input is asynchronous to `clk` and is synchronised internally. Each complete period produces one registered result with a single-cycle valid strobe. Loss of activity on the input is flagged by a timeout.

---
 rtl/clk_meter_pkg.sv | 14 +
 rtl/sync_edge_det.sv | 31 +++
 rtl/clk_period_meter.sv | 137 +++++++++++++
 tb/tb_clk_period_meter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// Shared types and default sizing for the slow-clock period meter.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_DEF     = 65535;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for a slow asynchronous input, with rise/fall detection
// on the synchronised level.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic sig_s,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              sig_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      sig_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], sig_in};
      sig_d  <= sync_q[STAGES-1];
    end
  end

  assign sig_s = sync_q[STAGES-1];
  assign rise  = sig_s & ~sig_d;
  assign fall  = ~sig_s & sig_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time (in clk cycles) of a slow square wave, with a
// sticky timeout when rising edges stop arriving.
//
// state   | meaning
// IDLE    | disabled, counters cleared
// ARM     | waiting for the first rising edge of a measurement run
// MEASURE | counting between rising edges, result on each rise
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [CNT_W-1:0] hcnt_q, hcnt_nxt;
  logic [CNT_W-1:0] period_nxt, high_time_nxt;
  logic             meas_valid_nxt, timeout_nxt;
  logic             sig_s, rise, sig_fall_unused;
  logic             timeout_hit;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .sig_s  (sig_s),
    .rise   (rise),
    .fall   (sig_fall_unused)
  );

  // A rise in the same cycle as the limit wins over the timeout.
  assign timeout_hit = (cnt_q == TIMEOUT_C) && !rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      hcnt_q     <= hcnt_nxt;
      period     <= period_nxt;
      high_time  <= high_time_nxt;
      meas_valid <= meas_valid_nxt;
      timeout    <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_nxt = ARM;
        ARM:     if (rise) state_nxt = MEASURE;
        MEASURE: if (timeout_hit) state_nxt = ARM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_nxt        = cnt_q;
    hcnt_nxt       = hcnt_q;
    period_nxt     = period;
    high_time_nxt  = high_time;
    meas_valid_nxt = 1'b0;
    timeout_nxt    = timeout;
    if (!enable) begin
      cnt_nxt     = '0;
      hcnt_nxt    = '0;
      timeout_nxt = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_nxt     = '0;
          hcnt_nxt    = '0;
          timeout_nxt = 1'b0;
        end
        ARM: begin
          if (rise) begin
            cnt_nxt  = ONE_C;
            hcnt_nxt = ONE_C;
          end else if (timeout_hit) begin
            cnt_nxt     = '0;
            hcnt_nxt    = '0;
            timeout_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_q + ONE_C;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_nxt     = cnt_q;
            high_time_nxt  = hcnt_q;
            meas_valid_nxt = 1'b1;
            timeout_nxt    = 1'b0;
            cnt_nxt        = ONE_C;
            hcnt_nxt       = ONE_C;
          end else if (timeout_hit) begin
            cnt_nxt     = '0;
            hcnt_nxt    = '0;
            timeout_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_q + ONE_C;
            if (sig_s) hcnt_nxt = hcnt_q + ONE_C;
          end
        end
        default: begin
          cnt_nxt  = '0;
          hcnt_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: waveform table plus hand-built
// timeout, enable-drop and reset sequences, results checked through a queue.
module tb_clk_period_meter;

  localparam int CNT_W = 16;
  localparam int TMO   = 100;

  logic             clk = 1'b0;
  logic             reset, enable, sig_in;
  logic [CNT_W-1:0] period, high_time;
  logic             meas_valid, timeout;

  typedef struct {
    int hi;
    int lo;
    int n;
    int exp_p;
    int exp_h;
  } vec_t;

  typedef struct {
    int p;
    int h;
  } exp_t;

  exp_t exp_q[$];
  exp_t prev;
  exp_t mon_e;
  bit   have_prev;
  vec_t vecs[5];
  int   n_cmp = 0;
  int   n_err = 0;

  clk_period_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2),
    .TIMEOUT     (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Every result the DUT emits must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (meas_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_meas_valid", 32'(meas_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("period", 32'(period), mon_e.p);
        check("high_time", 32'(high_time), mon_e.h);
        check("timeout_on_valid", 32'(timeout), 32'd0);
      end
    end
  end

  task automatic tick(input logic lvl);
    @(negedge clk);
    sig_in = lvl;
  endtask

  // Called just before driving a rising edge: the period that edge closes is now due.
  task automatic start_period(input int ep, input int eh);
    if (have_prev) exp_q.push_back(prev);
    prev.p    = ep;
    prev.h    = eh;
    have_prev = 1'b1;
  endtask

  task automatic run_ticks(input int hi, input int from, input int to);
    for (int i = from; i < to; i++) tick(i < hi);
  endtask

  task automatic run_period(input int hi, input int lo, input int ep, input int eh);
    start_period(ep, eh);
    run_ticks(hi, 0, hi + lo);
  endtask

  initial begin
    vecs[0] = '{hi: 4, lo: 4, n: 4, exp_p: 8,  exp_h: 4};
    vecs[1] = '{hi: 1, lo: 1, n: 6, exp_p: 2,  exp_h: 1};
    vecs[2] = '{hi: 2, lo: 2, n: 5, exp_p: 4,  exp_h: 2};
    vecs[3] = '{hi: 3, lo: 7, n: 4, exp_p: 10, exp_h: 3};
    vecs[4] = '{hi: 4, lo: 4, n: 4, exp_p: 8,  exp_h: 4};

    reset = 1'b1; enable = 1'b0; sig_in = 1'b0; have_prev = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period", 32'(period), 32'd0);
    check("rst_high_time", 32'(high_time), 32'd0);
    check("rst_meas_valid", 32'(meas_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    repeat (2) tick(1'b0);

    // Idle input: ARM counts 0..TMO, flag rises on the edge that sees cnt == TMO.
    enable = 1'b1; have_prev = 1'b0;
    repeat (TMO + 1) tick(1'b0);
    check("timeout_before_limit", 32'(timeout), 32'd0);
    tick(1'b0);
    check("timeout_at_limit", 32'(timeout), 32'd1);
    check("period_hold_on_timeout", 32'(period), 32'd0);

    // Timeout stays set through the first edge, clears with the first result.
    run_period(4, 4, 8, 4);
    check("timeout_sticky", 32'(timeout), 32'd1);
    run_period(4, 4, 8, 4);
    check("timeout_cleared", 32'(timeout), 32'd0);

    foreach (vecs[v]) begin
      for (int k = 0; k < vecs[v].n; k++)
        run_period(vecs[v].hi, vecs[v].lo, vecs[v].exp_p, vecs[v].exp_h);
    end

    // Enable low for 5 edges starting mid-high-phase of a clk/8 period.
    start_period(8, 4);
    run_ticks(4, 0, 4);
    enable = 1'b0; have_prev = 1'b0;
    run_ticks(4, 4, 8);
    check("dis_period_hold", 32'(period), 32'd8);
    check("dis_high_hold", 32'(high_time), 32'd4);
    check("dis_timeout", 32'(timeout), 32'd0);
    start_period(8, 4);
    run_ticks(4, 0, 1);
    enable = 1'b1;
    run_ticks(4, 1, 8);
    run_period(4, 4, 8, 4);
    run_period(4, 4, 8, 4);

    // Reset in the low phase, released before the next rising edge.
    start_period(8, 4);
    run_ticks(4, 0, 6);
    reset = 1'b1;
    #1;
    check("midrst_period", 32'(period), 32'd0);
    check("midrst_high_time", 32'(high_time), 32'd0);
    check("midrst_meas_valid", 32'(meas_valid), 32'd0);
    check("midrst_timeout", 32'(timeout), 32'd0);
    have_prev = 1'b0;
    run_ticks(4, 6, 8);
    reset = 1'b0;
    run_period(4, 4, 8, 4);
    check("postrst_no_result", 32'(period), 32'd0);
    run_period(4, 4, 8, 4);
    run_period(4, 4, 8, 4);

    repeat (10) tick(1'b0);
    check("results_outstanding", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
